// File: rtl/weight_pkg.sv
// Shared definitions for the weight fetch path: FSM encoding, word/byte geometry,
// default buffer depth and a byte-lane selector used by the unpacker.
package weight_pkg;

  localparam int WORD_BYTES         = 4;
  localparam int BYTE_W             = 8;
  localparam int WORD_W             = WORD_BYTES * BYTE_W;
  localparam int BYTE_IDX_W         = $clog2(WORD_BYTES);
  localparam int DEFAULT_FIFO_DEPTH = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } wfuState_t;

  function automatic logic [BYTE_W-1:0] selectByte(
    input logic [WORD_W-1:0]     word,
    input logic [BYTE_IDX_W-1:0] idx
  );
    return word[idx*BYTE_W +: BYTE_W];
  endfunction

endpackage

// File: rtl/weight_word_fifo.sv
// Synchronous word FIFO between the BRAM read port and the byte unpacker.
// Read data is combinational from the head entry so a pop and its use share one edge.
module weight_word_fifo
  import weight_pkg::*;
#(
  parameter int DEPTH = DEFAULT_FIFO_DEPTH,
  parameter int WIDTH = WORD_W
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_wrEn,
  input  logic [WIDTH-1:0]       i_wrData,
  input  logic                   i_rdEn,
  output logic [WIDTH-1:0]       o_rdData,
  output logic [$clog2(DEPTH):0] o_count,
  output logic                   o_empty,
  output logic                   o_full
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wrPtr;
  logic [PTR_W-1:0] r_rdPtr;
  logic [PTR_W:0]   r_count;

  logic w_push;
  logic w_pop;

  assign w_push = i_wrEn && !o_full;
  assign w_pop  = i_rdEn && !o_empty;

  // Storage carries no reset; validity is tracked entirely by the pointers and count.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wrPtr] <= i_wrData;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_wrPtr <= r_wrPtr + 1'b1;
      end
      if (w_pop) begin
        r_rdPtr <= r_rdPtr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_rdData = r_mem[r_rdPtr];
  assign o_count  = r_count;
  assign o_empty  = (r_count == '0);
  assign o_full   = (r_count == (PTR_W+1)'(DEPTH));

endmodule

// File: rtl/weight_fetch_unit.sv
// Streams a block of 32-bit weight words out of BRAM and hands them to the conv
// engine one signed byte at a time, LSB first, under valid/ready flow control.
module weight_fetch_unit
  import weight_pkg::*;
#(
  parameter int FIFO_DEPTH = DEFAULT_FIFO_DEPTH,
  parameter int CNT_W      = 7
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [31:0]      base_addr,
  input  logic [CNT_W-1:0] num_words,
  output logic [31:0]      bram_addr,
  output logic             bram_en,
  output logic [3:0]       bram_wen,
  output logic [31:0]      bram_din,
  input  logic [31:0]      bram_dout,
  output logic             w_valid,
  output logic [7:0]       w_data,
  input  logic             w_ready,
  output logic             busy,
  output logic             done
);

  localparam int FCNT_W = $clog2(FIFO_DEPTH) + 1;

  wfuState_t        r_state;
  logic [31:0]      r_base;
  logic [CNT_W-1:0] r_numWords;
  logic [CNT_W-1:0] r_issueCnt;
  logic             r_inflight;
  logic             r_busy;
  logic             r_done;

  logic [WORD_W-1:0]     r_word;
  logic [BYTE_IDX_W-1:0] r_byteIdx;
  logic                  r_wValid;
  logic [BYTE_W-1:0]     r_wData;

  logic [WORD_W-1:0] w_fifoData;
  logic [FCNT_W-1:0] w_fifoCount;
  logic              w_fifoEmpty;
  logic              w_fifoFull;
  logic [FCNT_W:0]   w_occupancy;
  logic              w_issue;
  logic              w_accept;
  logic              w_lastByte;
  logic              w_load;
  logic              w_drainDone;
  logic [31:0]       w_addr;

  // Credit check counts the read already in flight so the FIFO can never overflow.
  assign w_occupancy = {1'b0, w_fifoCount} + {{FCNT_W{1'b0}}, r_inflight};
  assign w_issue     = (r_state == ST_FETCH)
                    && (r_issueCnt < r_numWords)
                    && (w_occupancy < (FCNT_W+1)'(FIFO_DEPTH))
                    && !w_fifoFull;
  assign w_addr      = r_base + (32'(r_issueCnt) << 2);

  assign bram_en   = w_issue;
  assign bram_addr = (r_state == ST_FETCH) ? w_addr : 32'd0;
  assign bram_wen  = 4'b0000;
  assign bram_din  = 32'd0;

  assign w_accept    = r_wValid && w_ready;
  assign w_lastByte  = (r_byteIdx == BYTE_IDX_W'(WORD_BYTES - 1));
  assign w_load      = !w_fifoEmpty && (!r_wValid || (w_accept && w_lastByte));
  assign w_drainDone = w_fifoEmpty && !r_inflight && (!r_wValid || (w_accept && w_lastByte));

  weight_word_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (WORD_W)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .i_wrEn   (r_inflight),
    .i_wrData (bram_dout),
    .i_rdEn   (w_load),
    .o_rdData (w_fifoData),
    .o_count  (w_fifoCount),
    .o_empty  (w_fifoEmpty),
    .o_full   (w_fifoFull)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_base     <= '0;
      r_numWords <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            if (num_words != '0) begin
              r_base     <= base_addr;
              r_numWords <= num_words;
              r_busy     <= 1'b1;
              r_state    <= ST_FETCH;
            end else begin
              r_state <= ST_DONE;
            end
          end
        end
        ST_FETCH: begin
          if (r_issueCnt == r_numWords) begin
            r_state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (w_drainDone) begin
            r_busy  <= 1'b0;
            r_state <= ST_DONE;
          end
        end
        ST_DONE: begin
          r_done  <= 1'b1;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Read data returns one cycle after bram_en; r_inflight marks that cycle's FIFO write.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_issueCnt <= '0;
      r_inflight <= 1'b0;
    end else begin
      r_inflight <= w_issue;
      if (r_state == ST_IDLE) begin
        r_issueCnt <= '0;
      end else if (w_issue) begin
        r_issueCnt <= r_issueCnt + 1'b1;
      end
    end
  end

  // Loading on the 4th-byte handshake keeps the byte stream gap-free across words.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_word    <= '0;
      r_byteIdx <= '0;
      r_wValid  <= 1'b0;
      r_wData   <= '0;
    end else if (w_load) begin
      r_word    <= w_fifoData;
      r_byteIdx <= '0;
      r_wValid  <= 1'b1;
      r_wData   <= selectByte(w_fifoData, '0);
    end else if (w_accept) begin
      if (w_lastByte) begin
        r_wValid <= 1'b0;
      end else begin
        r_byteIdx <= r_byteIdx + 1'b1;
        r_wData   <= selectByte(r_word, r_byteIdx + 1'b1);
      end
    end
  end

  assign w_valid = r_wValid;
  assign w_data  = r_wData;
  assign busy    = r_busy;
  assign done    = r_done;

endmodule

// File: tb/tb_weight_fetch_unit.sv
// Directed bench for weight_fetch_unit: BRAM model with a fixed address-derived
// pattern, byte scoreboard filled at job start and drained on each handshake.
module tb_weight_fetch_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [31:0] base_addr = 32'd0;
  logic [6:0]  num_words = 7'd0;
  logic [31:0] bram_addr;
  logic        bram_en;
  logic [3:0]  bram_wen;
  logic [31:0] bram_din;
  logic [31:0] bram_dout = 32'd0;
  logic        w_valid;
  logic [7:0]  w_data;
  logic        w_ready = 1'b1;
  logic        busy;
  logic        done;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int jobStartCyc = 0;
  int byteCount = 0;
  int firstByteCyc = 0;
  int lastByteCyc = 0;
  int enCount = 0;
  int doneCount = 0;
  logic [31:0] lastAddr = 32'd0;
  bit toggleMode = 1'b0;
  bit prevStall = 1'b0;
  logic [7:0] prevData = 8'd0;
  logic [7:0] expQ[$];
  logic [31:0] addrQ[$];

  weight_fetch_unit dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .base_addr (base_addr),
    .num_words (num_words),
    .bram_addr (bram_addr),
    .bram_en   (bram_en),
    .bram_wen  (bram_wen),
    .bram_din  (bram_din),
    .bram_dout (bram_dout),
    .w_valid   (w_valid),
    .w_data    (w_data),
    .w_ready   (w_ready),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Weight memory contents: byte i of the word at addr, so a wrong address shows up as wrong data.
  function automatic logic [7:0] expByte(input logic [31:0] addr, input int i);
    logic [7:0] k;
    k = addr[9:2];
    return (8'(k << 2) + 8'(i + 1)) ^ addr[31:24];
  endfunction

  function automatic logic [31:0] memWord(input logic [31:0] addr);
    return {expByte(addr, 3), expByte(addr, 2), expByte(addr, 1), expByte(addr, 0)};
  endfunction

  always @(posedge clk) begin
    bram_dout <= bram_en ? memWord(bram_addr) : 32'hDEAD_BEEF;
  end

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    logic [7:0] e;
    if (rst) begin
      prevStall = 1'b0;
    end else begin
      if (prevStall) begin
        checkOutput("stall_hold", {55'd0, w_valid, w_data}, {55'd0, 1'b1, prevData});
      end
      if (w_valid && w_ready) begin
        if (expQ.size() == 0) begin
          checkOutput("extra_byte", 64'(w_data), 64'hFFFF_FFFF_FFFF_FFFF);
        end else begin
          e = expQ.pop_front();
          checkOutput("wdata", 64'(w_data), 64'(e));
        end
        if (byteCount == 0) firstByteCyc = cyc;
        lastByteCyc = cyc;
        byteCount++;
      end
      prevStall = w_valid && !w_ready;
      prevData  = w_data;
      if (bram_en) begin
        enCount++;
        lastAddr = bram_addr;
        addrQ.push_back(bram_addr);
      end
      if (done) doneCount++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    start = 1'b0;
    if (toggleMode) w_ready = ~w_ready;
  endtask

  // Pushes the expected byte stream and raises start for exactly the current cycle (cycle 0).
  task automatic applyStimulus(input logic [31:0] base, input logic [6:0] num);
    for (int w = 0; w < int'(num); w++) begin
      for (int i = 0; i < 4; i++) begin
        expQ.push_back(expByte(base + 32'(w * 4), i));
      end
    end
    tick();
    byteCount   = 0;
    enCount     = 0;
    doneCount   = 0;
    addrQ.delete();
    jobStartCyc = cyc;
    base_addr   = base;
    num_words   = num;
    start       = 1'b1;
  endtask

  task automatic waitDone(input string tag, input int limit);
    bit seen;
    seen = 1'b0;
    for (int n = 0; n < limit && !seen; n++) begin
      tick();
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    checkOutput(tag, 64'(seen), 64'd1);
    tick();
    @(negedge clk);
    checkOutput({tag, "_pulse_end"}, 64'(done), 64'd0);
  endtask

  initial begin
    $display("[TB] reset");
    rst = 1'b1;
    tick();
    tick();
    @(negedge clk);
    checkOutput("rst_bram_addr", 64'(bram_addr), 64'd0);
    checkOutput("rst_bram_en", 64'(bram_en), 64'd0);
    checkOutput("rst_w_valid", 64'(w_valid), 64'd0);
    checkOutput("rst_w_data", 64'(w_data), 64'd0);
    checkOutput("rst_busy_done", {62'd0, busy, done}, 64'd0);
    checkOutput("bram_wen_din", {28'd0, bram_wen, bram_din}, 64'd0);
    tick();
    rst = 1'b0;
    tick();

    $display("[TB] single word timing");
    applyStimulus(32'h0000_0000, 7'd1);
    for (int k = 1; k <= 11; k++) begin
      tick();
      @(negedge clk);
      checkOutput($sformatf("t1_valid_c%0d", k), 64'(w_valid), 64'(k >= 4 && k <= 7));
      checkOutput($sformatf("t1_done_c%0d", k), 64'(done), 64'(k == 9));
      checkOutput($sformatf("t1_busy_c%0d", k), 64'(busy), 64'(k >= 1 && k <= 7));
    end
    checkOutput("t1_first_latency", 64'(firstByteCyc - jobStartCyc), 64'd4);
    checkOutput("t1_bytes", 64'(byteCount), 64'd4);
    checkOutput("t1_done_count", 64'(doneCount), 64'd1);

    $display("[TB] 65-word bank streaming");
    applyStimulus(32'h0000_0000, 7'd65);
    waitDone("t2_done", 400);
    checkOutput("t2_bytes", 64'(byteCount), 64'd260);
    checkOutput("t2_first_latency", 64'(firstByteCyc - jobStartCyc), 64'd4);
    checkOutput("t2_no_gaps", 64'(lastByteCyc - firstByteCyc + 1), 64'd260);
    checkOutput("t2_last_addr", 64'(lastAddr), 64'h100);
    checkOutput("t2_reads", 64'(enCount), 64'd65);
    checkOutput("t2_done_count", 64'(doneCount), 64'd1);

    $display("[TB] toggling ready");
    w_ready    = 1'b1;
    toggleMode = 1'b1;
    applyStimulus(32'h0000_1180, 7'd8);
    waitDone("t3_done", 300);
    toggleMode = 1'b0;
    w_ready    = 1'b1;
    checkOutput("t3_bytes", 64'(byteCount), 64'd32);
    checkOutput("t3_queue_empty", 64'(expQ.size()), 64'd0);

    $display("[TB] zero-length job");
    applyStimulus(32'h0000_0300, 7'd0);
    for (int k = 1; k <= 4; k++) begin
      tick();
      @(negedge clk);
      checkOutput($sformatf("t4_done_c%0d", k), 64'(done), 64'(k == 2));
      checkOutput($sformatf("t4_busy_c%0d", k), 64'(busy), 64'd0);
    end
    checkOutput("t4_reads", 64'(enCount), 64'd0);

    $display("[TB] reset mid-job");
    applyStimulus(32'h0000_0200, 7'd16);
    for (int k = 1; k <= 10; k++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    checkOutput("t5_bram_addr", 64'(bram_addr), 64'd0);
    checkOutput("t5_bram_en", 64'(bram_en), 64'd0);
    checkOutput("t5_w_valid", 64'(w_valid), 64'd0);
    checkOutput("t5_w_data", 64'(w_data), 64'd0);
    checkOutput("t5_busy_done", {62'd0, busy, done}, 64'd0);
    expQ.delete();
    for (int k = 0; k < 6; k++) tick();
    checkOutput("t5_no_done", 64'(doneCount), 64'd0);
    applyStimulus(32'h0000_0040, 7'd2);
    waitDone("t5_restart_done", 100);
    checkOutput("t5_restart_bytes", 64'(byteCount), 64'd8);

    $display("[TB] address wrap");
    applyStimulus(32'hFFFF_FFFC, 7'd2);
    waitDone("t6_done", 100);
    checkOutput("t6_reads", 64'(addrQ.size()), 64'd2);
    if (addrQ.size() >= 2) begin
      checkOutput("t6_addr0", 64'(addrQ[0]), 64'hFFFF_FFFC);
      checkOutput("t6_addr1", 64'(addrQ[1]), 64'h0000_0000);
    end
    checkOutput("t6_bytes", 64'(byteCount), 64'd8);
    checkOutput("final_queue_empty", 64'(expQ.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
